coco_multi_timer: RTL and testbench

//  Parametrised multi-channel bus timer; successor to the single-channel counter peripheral.
//  NUM_CH independent down-counters, each with its own register block on the word bus.
//  Per-channel one-shot/auto-reload modes, W1C pending flags, maskable per-channel IRQs.

---
 rtl/coco_multi_timer_if.sv | 23 ++
 rtl/coco_multi_timer.sv | 155 +++++++++++++++
 tb/tb_coco_multi_timer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coco_multi_timer_if.sv
// Word-bus interface for coco_multi_timer: address/strobe/data from the CPU side,
// read data and interrupt lines back from the timer.
interface coco_multi_timer_if #(
    parameter int NUM_CH = 4,
    parameter int CH_AW  = 2
);
    logic [CH_AW+1:0]  ADD_I;
    logic              WE_I;
    logic [31:0]       DAT_I;
    logic [31:0]       DAT_O;
    logic              IRQ;
    logic [NUM_CH-1:0] IRQ_VEC;

    modport master (
        output ADD_I, WE_I, DAT_I,
        input  DAT_O, IRQ, IRQ_VEC
    );

    modport slave (
        input  ADD_I, WE_I, DAT_I,
        output DAT_O, IRQ, IRQ_VEC
    );
endinterface

// File: rtl/coco_multi_timer.sv
// coco_multi_timer: NUM_CH independent down-counters on a word bus.
// Per channel: CTRL (EN, MODE, IM, CASC), PRESET, COUNT, STATUS (W1C PEND).
// Optional macro COCO_TIMER_CASCADE_EN: a channel with CASC=1 ticks only on
// the previous channel's terminal event; without it CASC is not stored.
module coco_multi_timer #(
    parameter int NUM_CH = 4,
    parameter int CH_AW  = 2,
    parameter int WIDTH  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    coco_multi_timer_if.slave   bus
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] im_q;
    logic [NUM_CH-1:0] pend_q;
    logic [1:0]        mode_q   [NUM_CH];
    logic [WIDTH-1:0]  preset_q [NUM_CH];
    logic [WIDTH-1:0]  count_q  [NUM_CH];
`ifdef COCO_TIMER_CASCADE_EN
    logic [NUM_CH-1:0] casc_q;
`endif

    logic [CH_AW-1:0]  ch_idx;
    logic [1:0]        reg_idx;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] term;
    logic [31:0]       rd_data;

    assign reg_idx = bus.ADD_I[1:0];
    assign ch_idx  = bus.ADD_I[CH_AW+1:2];

    // Write strobe per channel; channel indices beyond NUM_CH never match.
    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            wr_sel[k] = bus.WE_I && (ch_idx == CH_AW'(k));
        end
    end

    // Tick and terminal-event generation; cascade events ripple down the chain in one cycle.
    always_comb begin
`ifdef COCO_TIMER_CASCADE_EN
        logic prev_term;
        prev_term = 1'b0;
`endif
        tick = '0;
        term = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            tick[k] = en_q[k];
`ifdef COCO_TIMER_CASCADE_EN
            if (k != 0 && casc_q[k]) begin
                tick[k] = en_q[k] && prev_term;
            end
`endif
            term[k] = tick[k] && (count_q[k] == CNT_ONE);
`ifdef COCO_TIMER_CASCADE_EN
            prev_term = term[k];
`endif
        end
    end

    // Channel state: counting first, then bus writes override, PEND set always wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= '0;
            im_q   <= '0;
            pend_q <= '0;
`ifdef COCO_TIMER_CASCADE_EN
            casc_q <= '0;
`endif
            for (int k = 0; k < NUM_CH; k++) begin
                mode_q[k]   <= 2'b00;
                preset_q[k] <= '0;
                count_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (term[k]) begin
                    if (mode_q[k] == 2'b01) begin
                        count_q[k] <= preset_q[k];
                    end else begin
                        count_q[k] <= '0;
                        en_q[k]    <= 1'b0;
                    end
                end else if (tick[k] && count_q[k] != '0) begin
                    count_q[k] <= count_q[k] - CNT_ONE;
                end

                if (wr_sel[k]) begin
                    case (reg_idx)
                        REG_CTRL: begin
                            en_q[k]   <= bus.DAT_I[0];
                            mode_q[k] <= bus.DAT_I[2:1];
                            im_q[k]   <= bus.DAT_I[3];
`ifdef COCO_TIMER_CASCADE_EN
                            casc_q[k] <= bus.DAT_I[4];
`endif
                            // Only a rising EN loads the counter; rewriting CTRL while running does not.
                            if (!en_q[k] && bus.DAT_I[0]) begin
                                count_q[k] <= preset_q[k];
                            end
                        end
                        REG_PRESET: preset_q[k] <= bus.DAT_I[WIDTH-1:0];
                        REG_COUNT:  count_q[k]  <= bus.DAT_I[WIDTH-1:0];
                        default: begin
                            if (bus.DAT_I[0]) begin
                                pend_q[k] <= 1'b0;
                            end
                        end
                    endcase
                end

                if (term[k]) begin
                    pend_q[k] <= 1'b1;
                end
            end
        end
    end

    // Read mux, combinational from the address; unmatched channels read 0.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_idx == CH_AW'(k)) begin
                case (reg_idx)
                    REG_CTRL: begin
                        rd_data[0]   = en_q[k];
                        rd_data[2:1] = mode_q[k];
                        rd_data[3]   = im_q[k];
`ifdef COCO_TIMER_CASCADE_EN
                        rd_data[4]   = casc_q[k];
`endif
                    end
                    REG_PRESET: rd_data[WIDTH-1:0] = preset_q[k];
                    REG_COUNT:  rd_data[WIDTH-1:0] = count_q[k];
                    default:    rd_data[0]         = pend_q[k];
                endcase
            end
        end
    end

    assign bus.DAT_O   = rd_data;
    assign bus.IRQ_VEC = pend_q & im_q;
    assign bus.IRQ     = |(pend_q & im_q);

endmodule

// File: tb/tb_coco_multi_timer.sv
// Directed bench for coco_multi_timer (NUM_CH=4, CH_AW=2, WIDTH=32).
module tb_coco_multi_timer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    coco_multi_timer_if #(.NUM_CH(4), .CH_AW(2)) bus ();

    coco_multi_timer #(.NUM_CH(4), .CH_AW(2), .WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single write: drive now (posedge+1 region), commit on the next edge, return at posedge+1.
    task automatic wr(input int ch, input int r, input logic [31:0] d);
        bus.ADD_I = {ch[1:0], r[1:0]};
        bus.DAT_I = d;
        bus.WE_I  = 1'b1;
        @(posedge clk);
        #1;
        bus.WE_I  = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] d);
        bus.ADD_I = {ch[1:0], r[1:0]};
        #1;
        d = bus.DAT_O;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        for (int ch = 0; ch < 4; ch++) begin
            for (int r = 0; r < 4; r++) begin
                rd(ch, r, v);
                checks++;
                if (v !== 32'h0) begin
                    $display("FAIL reset_reg ch%0d r%0d got %h exp 0", ch, r, v);
                    errors++;
                end
            end
        end
        checks++;
        if (bus.IRQ !== 1'b0 || bus.IRQ_VEC !== 4'h0) begin
            $display("FAIL reset_irq got %b/%b exp 0/0000", bus.IRQ, bus.IRQ_VEC);
            errors++;
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        wr(0, 1, 32'd5);
        wr(0, 0, 32'h9);
        rd(0, 2, v);
        checks++;
        if (v !== 32'd5) begin
            $display("FAIL oneshot_load got %0d exp 5", v);
            errors++;
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            rd(0, 2, v);
            checks++;
            if (v !== 32'(5 - i)) begin
                $display("FAIL oneshot_count step %0d got %0d exp %0d", i, v, 5 - i);
                errors++;
            end
            checks++;
            if (bus.IRQ !== (i == 5)) begin
                $display("FAIL oneshot_irq step %0d got %b exp %b", i, bus.IRQ, (i == 5));
                errors++;
            end
        end
        rd(0, 0, v);
        checks++;
        if (v !== 32'h8) begin
            $display("FAIL oneshot_ctrl got %h exp 8", v);
            errors++;
        end
        step();
        step();
        rd(0, 2, v);
        checks++;
        if (v !== 32'h0 || bus.IRQ !== 1'b1) begin
            $display("FAIL oneshot_hold count %0d irq %b exp 0/1", v, bus.IRQ);
            errors++;
        end
        wr(0, 3, 32'h0);
        checks++;
        if (bus.IRQ !== 1'b1) begin
            $display("FAIL status_w0 irq got %b exp 1", bus.IRQ);
            errors++;
        end
        wr(0, 3, 32'h1);
        checks++;
        if (bus.IRQ !== 1'b0 || bus.IRQ_VEC !== 4'h0) begin
            $display("FAIL status_w1c irq %b vec %b exp 0/0000", bus.IRQ, bus.IRQ_VEC);
            errors++;
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        logic [31:0] exp_cnt [6];
        exp_cnt = '{32'd2, 32'd1, 32'd3, 32'd2, 32'd1, 32'd3};
        wr(1, 1, 32'd3);
        wr(1, 0, 32'hB);
        for (int i = 1; i <= 6; i++) begin
            step();
            rd(1, 2, v);
            checks++;
            if (v !== exp_cnt[i-1]) begin
                $display("FAIL reload_count step %0d got %0d exp %0d", i, v, exp_cnt[i-1]);
                errors++;
            end
            checks++;
            if (bus.IRQ_VEC[1] !== (i >= 3)) begin
                $display("FAIL reload_irqvec step %0d got %b exp %b", i, bus.IRQ_VEC[1], (i >= 3));
                errors++;
            end
        end
        // count is 3: this clear lands on a plain decrement edge
        wr(1, 3, 32'h1);
        rd(1, 3, v);
        checks++;
        if (v !== 32'h0) begin
            $display("FAIL reload_clear got %h exp 0", v);
            errors++;
        end
        step();
        // count is 1: next edge is terminal, set beats clear
        wr(1, 3, 32'h1);
        rd(1, 3, v);
        checks++;
        if (v !== 32'h1) begin
            $display("FAIL clear_on_terminal pend got %h exp 1", v);
            errors++;
        end
        rd(1, 2, v);
        checks++;
        if (v !== 32'd3) begin
            $display("FAIL terminal_reload count got %0d exp 3", v);
            errors++;
        end
        rd(0, 2, v);
        checks++;
        if (v !== 32'h0 || bus.IRQ_VEC[0] !== 1'b0) begin
            $display("FAIL ch0_isolation count %0d vec0 %b exp 0/0", v, bus.IRQ_VEC[0]);
            errors++;
        end
        wr(1, 2, 32'h10);
        rd(1, 2, v);
        checks++;
        if (v !== 32'h10) begin
            $display("FAIL count_write got %h exp 10", v);
            errors++;
        end
        step();
        rd(1, 2, v);
        checks++;
        if (v !== 32'hF) begin
            $display("FAIL count_after_write got %h exp f", v);
            errors++;
        end
        wr(1, 0, 32'h0);
        wr(1, 3, 32'h1);
    endtask

    task automatic test_mask();
        logic [31:0] v;
        wr(2, 1, 32'd2);
        wr(2, 0, 32'h3);
        step();
        step();
        rd(2, 3, v);
        checks++;
        if (v !== 32'h1) begin
            $display("FAIL mask_pend got %h exp 1", v);
            errors++;
        end
        checks++;
        if (bus.IRQ !== 1'b0 || bus.IRQ_VEC !== 4'h0) begin
            $display("FAIL mask_irq irq %b vec %b exp 0/0000", bus.IRQ, bus.IRQ_VEC);
            errors++;
        end
        // count is 2 here; keeping EN=1 must decrement, not reload
        wr(2, 0, 32'hB);
        rd(2, 2, v);
        checks++;
        if (v !== 32'd1) begin
            $display("FAIL unmask_no_reload count got %0d exp 1", v);
            errors++;
        end
        checks++;
        if (bus.IRQ !== 1'b1 || bus.IRQ_VEC !== 4'b0100) begin
            $display("FAIL unmask_irq irq %b vec %b exp 1/0100", bus.IRQ, bus.IRQ_VEC);
            errors++;
        end
        wr(2, 0, 32'h0);
        wr(2, 3, 32'h1);
    endtask

    task automatic test_preset_zero();
        logic [31:0] v;
        logic [31:0] exp_ctrl;
`ifdef COCO_TIMER_CASCADE_EN
        exp_ctrl = 32'h1F;
`else
        exp_ctrl = 32'h0F;
`endif
        wr(3, 1, 32'h0);
        wr(3, 0, 32'hFFFF_FFFF);
        step();
        step();
        step();
        rd(3, 0, v);
        checks++;
        if (v !== exp_ctrl) begin
            $display("FAIL ctrl_readback got %h exp %h", v, exp_ctrl);
            errors++;
        end
        rd(3, 2, v);
        checks++;
        if (v !== 32'h0) begin
            $display("FAIL preset0_count got %h exp 0", v);
            errors++;
        end
        rd(3, 3, v);
        checks++;
        if (v !== 32'h0) begin
            $display("FAIL preset0_pend got %h exp 0", v);
            errors++;
        end
        wr(3, 0, 32'h0);
    endtask

    task automatic test_cascade();
        logic [31:0] v;
        logic [31:0] exp_ctrl;
        int          t_pend;
`ifdef COCO_TIMER_CASCADE_EN
        exp_ctrl = 32'h1B;
        t_pend   = 8;
`else
        exp_ctrl = 32'h0B;
        t_pend   = 3;
`endif
        wr(1, 1, 32'd3);
        wr(1, 0, 32'h1B);
        rd(1, 0, v);
        checks++;
        if (v !== exp_ctrl) begin
            $display("FAIL casc_ctrl got %h exp %h", v, exp_ctrl);
            errors++;
        end
        for (int n = 1; n <= 10; n++) begin
            if (n == 1)      wr(0, 1, 32'd2);
            else if (n == 2) wr(0, 0, 32'h3);
            else             step();
            rd(1, 3, v);
            checks++;
            if (v[0] !== (n >= t_pend)) begin
                $display("FAIL casc_pend edge %0d got %b exp %b", n, v[0], (n >= t_pend));
                errors++;
            end
        end
    endtask

    task automatic test_reset_async();
        logic [31:0] v;
        checks++;
        if (bus.IRQ !== 1'b1) begin
            $display("FAIL pre_reset_irq got %b exp 1", bus.IRQ);
            errors++;
        end
        rst_n = 1'b0;
        rd(0, 0, v);
        checks++;
        if (v !== 32'h0) begin
            $display("FAIL async_ctrl got %h exp 0", v);
            errors++;
        end
        rd(0, 2, v);
        checks++;
        if (v !== 32'h0) begin
            $display("FAIL async_count got %h exp 0", v);
            errors++;
        end
        rd(1, 3, v);
        checks++;
        if (v !== 32'h0 || bus.IRQ !== 1'b0 || bus.IRQ_VEC !== 4'h0) begin
            $display("FAIL async_irq pend %h irq %b vec %b exp 0/0/0000", v, bus.IRQ, bus.IRQ_VEC);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        rd(0, 2, v);
        checks++;
        if (v !== 32'h0) begin
            $display("FAIL post_reset_count got %h exp 0", v);
            errors++;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.ADD_I = '0;
        bus.WE_I  = 1'b0;
        bus.DAT_I = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        test_oneshot();
        test_autoreload();
        test_mask();
        test_preset_zero();
        test_cascade();
        test_reset_async();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
